// File: rtl/usb_tx_stuff_nrzi.sv
//------------------------------------------------------------------------------
// Module   : usb_tx_stuff_nrzi
// Purpose  : USB full-speed transmit line encoder. It pulls NRZ bits from an
//            upstream serializer once per bit time, optionally inserts a
//            stuffed 0 after six consecutive 1s, NRZI-encodes the result onto
//            D+/D-, and closes each packet with SE0, SE0, J.
// Config   : define USB_TX_BITSTUFF_EN to enable bit stuffing. When it is
//            undefined, every valid data bit is sent as-is.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usb_tx_stuff_nrzi (
   input  logic clk,
   input  logic nRST,
   input  logic bit_tick,
   input  logic tx_start,
   input  logic bit_valid,
   input  logic bit_in,
   output logic bit_req,
   output logic dp,
   output logic dm,
   output logic tx_active
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DATA = 3'd1,
      S_EOP1 = 3'd2,
      S_EOP2 = 3'd3,
      S_EOPJ = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   dp_q, dp_d;
   logic   dm_q, dm_d;
   logic   tx_active_q, tx_active_d;
   logic   bit_req_c;

   // One emitted bit on the line this tick, and its NRZ value.
   logic   emit_en;
   logic   emit_val;

   // High when the next bit time must carry a stuffed 0.
   logic   stuff_pend;

`ifdef USB_TX_BITSTUFF_EN
   logic [2:0] ones_cnt_q, ones_cnt_d;

   assign stuff_pend = (ones_cnt_q == 3'd6);

   // Run-length of emitted 1s; restarts at every packet and every emitted 0.
   always_comb begin
      ones_cnt_d = ones_cnt_q;
      if (state_q == S_IDLE) begin
         if (tx_start) begin
            ones_cnt_d = 3'd0;
         end
      end else if (emit_en) begin
         ones_cnt_d = emit_val ? (ones_cnt_q + 3'd1) : 3'd0;
      end
   end

   // Ones counter register, cleared asynchronously with the rest of the block.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ones_cnt_q <= 3'd0;
      end else begin
         ones_cnt_q <= ones_cnt_d;
      end
   end
`else
   assign stuff_pend = 1'b0;
`endif

   // Next-state, line and handshake decode for the packet sequencer.
   always_comb begin
      state_d     = state_q;
      dp_d        = dp_q;
      dm_d        = dm_q;
      tx_active_d = tx_active_q;
      bit_req_c   = 1'b0;
      emit_en     = 1'b0;
      emit_val    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Line rests at J; a tick coinciding with tx_start is not a bit.
            dp_d = 1'b1;
            dm_d = 1'b0;
            if (tx_start) begin
               state_d     = S_DATA;
               tx_active_d = 1'b1;
            end
         end

         S_DATA: begin
            if (bit_tick) begin
               if (stuff_pend) begin
                  // Stuffed 0 is owed regardless of upstream, and is not an
                  // upstream bit, so no acknowledge.
                  emit_en  = 1'b1;
                  emit_val = 1'b0;
               end else if (bit_valid) begin
                  emit_en   = 1'b1;
                  emit_val  = bit_in;
                  bit_req_c = 1'b1;
               end else begin
                  state_d = S_EOP1;
                  dp_d    = 1'b0;
                  dm_d    = 1'b0;
               end

               // NRZI: a 0 swaps J and K, a 1 leaves the line alone. The line
               // is always J or K while in DATA, so swapping dp/dm toggles.
               if (emit_en && !emit_val) begin
                  dp_d = dm_q;
                  dm_d = dp_q;
               end
            end
         end

         S_EOP1: begin
            if (bit_tick) begin
               state_d = S_EOP2;
               dp_d    = 1'b0;
               dm_d    = 1'b0;
            end
         end

         S_EOP2: begin
            if (bit_tick) begin
               state_d = S_EOPJ;
               dp_d    = 1'b1;
               dm_d    = 1'b0;
            end
         end

         S_EOPJ: begin
            if (bit_tick) begin
               state_d     = S_IDLE;
               tx_active_d = 1'b0;
               dp_d        = 1'b1;
               dm_d        = 1'b0;
            end
         end

         default: begin
            state_d     = S_IDLE;
            tx_active_d = 1'b0;
            dp_d        = 1'b1;
            dm_d        = 1'b0;
         end
      endcase
   end

   // State and registered line drivers; reset parks the line at J at once.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         dp_q        <= 1'b1;
         dm_q        <= 1'b0;
         tx_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dp_q        <= dp_d;
         dm_q        <= dm_d;
         tx_active_q <= tx_active_d;
      end
   end

   assign dp        = dp_q;
   assign dm        = dm_q;
   assign tx_active = tx_active_q;
   assign bit_req   = bit_req_c;

endmodule

`default_nettype wire

// File: tb/tb_usb_tx_stuff_nrzi.sv
`default_nettype none

module tb_usb_tx_stuff_nrzi;

   localparam logic [1:0] LJ   = 2'b10;
   localparam logic [1:0] LK   = 2'b01;
   localparam logic [1:0] LSE0 = 2'b00;

   logic clk;
   logic nRST;
   logic bit_tick;
   logic tx_start;
   logic bit_valid;
   logic bit_in;
   logic bit_req;
   logic dp;
   logic dm;
   logic tx_active;

   int n_vec;
   int n_err;

   usb_tx_stuff_nrzi dut (
      .clk       (clk),
      .nRST      (nRST),
      .bit_tick  (bit_tick),
      .tx_start  (tx_start),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .bit_req   (bit_req),
      .dp        (dp),
      .dm        (dm),
      .tx_active (tx_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bit time: an idle clk, then a one-clk tick. bit_req is sampled
   // mid-tick, the line just after the tick edge.
   task automatic do_tick(input logic v, input logic b,
                          output logic req, output logic [1:0] line);
      @(posedge clk);
      @(negedge clk);
      bit_tick  = 1'b1;
      bit_valid = v;
      bit_in    = b;
      #1;
      req = bit_req;
      @(posedge clk);
      #1;
      bit_tick = 1'b0;
      line     = {dp, dm};
   endtask

   task automatic start_pkt();
      @(negedge clk);
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
   endtask

   // Bounded return to IDLE between scenarios.
   task automatic drain();
      logic       r;
      logic [1:0] l;
      for (int i = 0; i < 8 && tx_active; i++) begin
         do_tick(1'b0, 1'b0, r, l);
      end
      if (tx_active) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: tx_active=%b required 0", tx_active);
      end
      bit_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic       r;
      logic [1:0] l;
      nRST = 1'b0;
      #12;
      n_vec++;
      if ({dp, dm, tx_active, bit_req} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_hold: dp,dm,act,req=%b required 1000", {dp, dm, tx_active, bit_req});
      end
      @(negedge clk);
      nRST = 1'b1;
      for (int i = 0; i < 10; i++) begin
         do_tick(1'b0, 1'b0, r, l);
         n_vec++;
         if ({l, tx_active, r} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_idle tick %0d: dp,dm,act,req=%b required 1000", i, {l, tx_active, r});
         end
      end
   endtask

   task automatic test_start_tick();
      logic       r;
      logic [1:0] l;
      @(negedge clk);
      tx_start  = 1'b1;
      bit_tick  = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      #1;
      n_vec++;
      if (bit_req !== 1'b0) begin
         n_err++;
         $display("FAIL start_tick_req: bit_req=%b required 0", bit_req);
      end
      @(posedge clk);
      #1;
      tx_start = 1'b0;
      bit_tick = 1'b0;
      n_vec++;
      if ({dp, dm, tx_active} !== 3'b101) begin
         n_err++;
         $display("FAIL start_tick_line: dp,dm,act=%b required 101", {dp, dm, tx_active});
      end
      do_tick(1'b1, 1'b0, r, l);
      n_vec++;
      if ({r, l} !== {1'b1, LK}) begin
         n_err++;
         $display("FAIL start_first_bit: req,line=%b required 101", {r, l});
      end
      drain();
   endtask

   task automatic test_nrzi();
      logic       r;
      logic [1:0] l;
      logic       bits [0:4];
      logic [1:0] exp  [0:4];
      bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      exp  = '{LK, LJ, LJ, LJ, LK};
      start_pkt();
      n_vec++;
      if ({dp, dm, tx_active} !== 3'b101) begin
         n_err++;
         $display("FAIL nrzi_start: dp,dm,act=%b required 101", {dp, dm, tx_active});
      end
      for (int i = 0; i < 5; i++) begin
         do_tick(1'b1, bits[i], r, l);
         n_vec++;
         if ({r, l} !== {1'b1, exp[i]}) begin
            n_err++;
            $display("FAIL nrzi_bit %0d: req,line=%b required %b", i, {r, l}, {1'b1, exp[i]});
         end
      end
      exp = '{LSE0, LSE0, LJ, LJ, LJ};
      for (int i = 0; i < 4; i++) begin
         do_tick(1'b0, 1'b0, r, l);
         n_vec++;
         if ({r, l, tx_active} !== {1'b0, exp[i], (i < 3)}) begin
            n_err++;
            $display("FAIL nrzi_eop %0d: req,line,act=%b required %b", i, {r, l, tx_active}, {1'b0, exp[i], (i < 3)});
         end
      end
   endtask

`ifdef USB_TX_BITSTUFF_EN
   task automatic test_stuff();
      logic       r;
      logic [1:0] l;
      logic       exp_r [0:8];
      logic [1:0] exp_l [0:8];
      logic       bits  [0:8];
      bits  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      exp_r = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
      exp_l = '{LJ, LJ, LJ, LJ, LJ, LJ, LK, LK, LJ};
      start_pkt();
      for (int i = 0; i < 9; i++) begin
         do_tick(1'b1, bits[i], r, l);
         n_vec++;
         if ({r, l} !== {exp_r[i], exp_l[i]}) begin
            n_err++;
            $display("FAIL stuff tick %0d: req,line=%b required %b", i, {r, l}, {exp_r[i], exp_l[i]});
         end
      end
      drain();
   endtask

   task automatic test_eop_stuff();
      logic       r;
      logic [1:0] l;
      logic [1:0] exp [0:4];
      exp = '{LK, LSE0, LSE0, LJ, LJ};
      start_pkt();
      for (int i = 0; i < 6; i++) begin
         do_tick(1'b1, 1'b1, r, l);
         n_vec++;
         if ({r, l} !== {1'b1, LJ}) begin
            n_err++;
            $display("FAIL eop_stuff_ones %0d: req,line=%b required 110", i, {r, l});
         end
      end
      for (int i = 0; i < 5; i++) begin
         do_tick(1'b0, 1'b0, r, l);
         n_vec++;
         if ({r, l, tx_active} !== {1'b0, exp[i], (i < 4)}) begin
            n_err++;
            $display("FAIL eop_stuff %0d: req,line,act=%b required %b", i, {r, l, tx_active}, {1'b0, exp[i], (i < 4)});
         end
      end
   endtask
`else
   task automatic test_no_stuff();
      logic       r;
      logic [1:0] l;
      start_pkt();
      for (int i = 0; i < 8; i++) begin
         do_tick(1'b1, 1'b1, r, l);
         n_vec++;
         if ({r, l} !== {1'b1, LJ}) begin
            n_err++;
            $display("FAIL no_stuff tick %0d: req,line=%b required 110", i, {r, l});
         end
      end
      do_tick(1'b1, 1'b0, r, l);
      n_vec++;
      if ({r, l} !== {1'b1, LK}) begin
         n_err++;
         $display("FAIL no_stuff_zero: req,line=%b required 101", {r, l});
      end
      drain();
   endtask
`endif

   task automatic test_abort();
      logic       r;
      logic [1:0] l;
      logic [1:0] exp [0:3];
      exp = '{LSE0, LJ, LJ, LJ};
      start_pkt();
      do_tick(1'b1, 1'b0, r, l);
      n_vec++;
      if (l !== LK) begin
         n_err++;
         $display("FAIL abort_pre_line: line=%b required %b", l, LK);
      end
      @(negedge clk);
      bit_tick  = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      #1;
      n_vec++;
      if (bit_req !== 1'b1) begin
         n_err++;
         $display("FAIL abort_pre_req: bit_req=%b required 1", bit_req);
      end
      #1;
      nRST = 1'b0;
      #1;
      n_vec++;
      if ({dp, dm, tx_active, bit_req} !== 4'b1000) begin
         n_err++;
         $display("FAIL abort_async: dp,dm,act,req=%b required 1000", {dp, dm, tx_active, bit_req});
      end
      bit_tick = 1'b0;
      @(negedge clk);
      nRST = 1'b1;
      do_tick(1'b1, 1'b0, r, l);
      n_vec++;
      if ({r, l, tx_active} !== 4'b0100) begin
         n_err++;
         $display("FAIL abort_idle: req,line,act=%b required 0100", {r, l, tx_active});
      end
      // Packet with no data, then a tx_start pulse while in EOP1.
      start_pkt();
      do_tick(1'b0, 1'b0, r, l);
      n_vec++;
      if (l !== LSE0) begin
         n_err++;
         $display("FAIL eop1_entry: line=%b required %b", l, LSE0);
      end
      start_pkt();
      for (int i = 0; i < 4; i++) begin
         do_tick(1'b1, 1'b0, r, l);
         n_vec++;
         if ({r, l, tx_active} !== {1'b0, exp[i], (i < 2)}) begin
            n_err++;
            $display("FAIL eop1_start_ignored %0d: req,line,act=%b required %b", i, {r, l, tx_active}, {1'b0, exp[i], (i < 2)});
         end
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      nRST      = 1'b0;
      bit_tick  = 1'b0;
      tx_start  = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      test_reset();
      test_start_tick();
      test_nrzi();
`ifdef USB_TX_BITSTUFF_EN
      test_stuff();
      test_eop_stuff();
`else
      test_no_stuff();
`endif
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/usb_tx_stuff_nrzi.md
USB_TX_STUFF_NRZI -- requirements
Module: usb_tx_stuff_nrzi

Interface
REQ-001 The block SHALL have an asynchronous active-low reset nRST and a clock clk.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- bit_tick  in  1  one-clk pulse per USB bit time (12 MHz enable).
- tx_start  in  1  begin a packet; sampled in IDLE only.
- bit_valid  in  1  upstream serializer holds a valid bit on bit_in.
- bit_in  in  1  current data bit, NRZ.
- bit_req  out  1  one-clk pulse; bit_in consumed; drives upstream shift_enable.
- dp  out  1  D+ line level, registered.
- dm  out  1  D- line level, registered.
- tx_active  out  1  high from packet start to end of EOP.

Function
REQ-003 Line states SHALL be: J = dp 1/dm 0; K = dp 0/dm 1; SE0 = dp 0/dm 0.
REQ-004 States SHALL be IDLE, DATA, EOP1, EOP2 and EOPJ; all transitions except IDLE->DATA occur only on bit_tick.
REQ-005 In IDLE, tx_start SHALL move the block to DATA on the next clk and set tx_active; a bit_tick in that same cycle is ignored.
REQ-006 tx_start outside IDLE SHALL be ignored.
REQ-007 In DATA on bit_tick, the block SHALL emit one bit by priority:
- if stuff pending (ones_cnt == 6): a stuffed 0; bit_req stays low.
- else if bit_valid: emit bit_in and pulse bit_req that same cycle.
- else: go to EOP1.
REQ-008 NRZI SHALL apply: an emitted 0 toggles J<->K; an emitted 1 holds the line level. The level before the first bit is J.
REQ-009 ones_cnt SHALL be a 3-bit counter: +1 per emitted 1, cleared by any emitted 0 (data or stuffed), and cleared on entry to DATA.
REQ-010 A stuffed bit SHALL NOT depend on bit_valid, so a stuff bit owed at end of data is sent before EOP.
REQ-011 The EOP sequence SHALL be:
- EOP1: drive SE0.
- EOP2: hold SE0.
- EOPJ: drive J.
- Next bit_tick: go to IDLE and clear tx_active.
REQ-012 Line outputs SHALL update on the clk edge after the bit_tick cycle, giving 1-clk latency from tick to line.
REQ-013 bit_req SHALL be high for at most 1 clk per bit_tick and never outside DATA.
REQ-014 In IDLE the line SHALL hold J.

Reset
REQ-015 While nRST is low, the block SHALL force IDLE, dp=1, dm=0, tx_active=0, bit_req=0 and ones_cnt=0, taking effect immediately.
REQ-016 Reset mid-packet SHALL abort with no EOP; the line returns to J and upstream is not acknowledged.

Configuration
REQ-017 The macro USB_TX_BITSTUFF_EN defined SHALL enable stuffing per REQ-007, REQ-009 and REQ-010.
REQ-018 Without USB_TX_BITSTUFF_EN, ones_cnt SHALL be absent, no stuffed bits are inserted, and every DATA bit_tick with bit_valid high emits bit_in and pulses bit_req.

Verification
REQ-019 Reset: release nRST with no stimulus -> dp=1, dm=0, tx_active=0, bit_req=0, held through 10 bit_ticks.
REQ-020 NRZI: tx_start, then bits 0,0,1,1,0 -> line K,J,J,J,K; 5 bit_req pulses, one per tick.
REQ-021 Stuffing (macro defined): bits 1 x7 then 0 -> line holds 6 ticks, toggles on tick 7 (stuffed) with no bit_req, then 7th 1 holds, then 0 toggles; 9 ticks carry 8 data bits.
REQ-022 EOP with owed stuff: six 1s, then bit_valid=0 -> stuff toggle, SE0, SE0, J, then tx_active falls on the following tick.
REQ-023 No stuffing (macro undefined): 8 consecutive 1s -> no line toggle, 8 consecutive bit_req pulses.
REQ-024 Abort: nRST low during DATA with line at K -> dp=1, dm=0 without waiting for clk; IDLE after release; a tx_start pulse during EOP1 is ignored.
